ws2812_frame_sequencer: RTL and testbench

Sequences the WS2812 capture/forward shift-register datapath for one pixel node. Sits between the bit decoder and the shift register, and performs these functions:
- Detects the WS2812 reset period (treset) on the synchronized data line.
- Gates decoded bits into the shift register.
- Counts captured and forwarded bits.
- Cross-checks the shift register's passthrough flag, then reports frame completion and sync errors to the status logic.

---
 rtl/ws2812_frame_sequencer.sv | 132 +++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_sequencer.sv
// WS2812 frame sequencer: detects treset on the line, gates decoded bits into the
// pixel shift register, counts captured/forwarded bits and flags passthrough mismatches.

package ws2812_frame_sequencer_pkg;

  typedef struct packed {
    logic valid;
    logic decode_bit;
    logic treset;
  } shift_reg_input_t;

endpackage

module ws2812_frame_sequencer
  import ws2812_frame_sequencer_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2500,
  parameter int unsigned FWD_CNT_W    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_din,
  input  logic                 i_bit_valid,
  input  logic                 i_bit_value,
  input  logic                 i_passthru_en,
  output shift_reg_input_t     o_shift_reg,
  output logic [4:0]           o_bit_count,
  output logic [FWD_CNT_W-1:0] o_fwd_count,
  output logic                 o_frame_done,
  output logic                 o_short_frame,
  output logic                 o_sync_err
);

  localparam int unsigned     IdleW   = $clog2(RESET_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(RESET_CYCLES);
  localparam logic [IdleW-1:0] IdleArm = IdleW'(RESET_CYCLES - 1);
  localparam logic [4:0]       LastBit = 5'd23;

  typedef enum logic [1:0] {
    StWaitReset,
    StCapture,
    StForward
  } state_e;

  state_e                 state_q;
  shift_reg_input_t       shift_q;
  logic [IdleW-1:0]       idle_q, idle_d;
  logic [4:0]             bit_cnt_q;
  logic [FWD_CNT_W-1:0]   fwd_cnt_q;
  logic                   frame_done_q;
  logic                   short_frame_q;
  logic                   sync_err_q;
  logic                   fwd_seen_q;
  logic                   det_reset;
  logic                   mismatch;

  // Saturating low-time counter; det_reset fires only on the step into saturation.
  always_comb begin
    idle_d = idle_q;
    if (i_din) begin
      idle_d = '0;
    end else if (idle_q != IdleMax) begin
      idle_d = idle_q + 1'b1;
    end
  end

  assign det_reset = !i_din && (idle_q == IdleArm);

  // First FORWARD cycle is exempt: the shift register reports its new mode one cycle late.
  assign mismatch = ((state_q == StForward) && fwd_seen_q && !i_passthru_en) ||
                    ((state_q == StCapture) && i_passthru_en);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= StWaitReset;
      shift_q       <= '0;
      idle_q        <= '0;
      bit_cnt_q     <= '0;
      fwd_cnt_q     <= '0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      sync_err_q    <= 1'b0;
      fwd_seen_q    <= 1'b0;
    end else begin
      idle_q        <= idle_d;
      shift_q       <= '0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      fwd_seen_q    <= (state_q == StForward);
      if (det_reset) begin
        // treset wins over a coincident bit strobe
        state_q        <= StCapture;
        shift_q.treset <= 1'b1;
        bit_cnt_q      <= '0;
        fwd_cnt_q      <= '0;
        frame_done_q   <= (state_q == StForward);
        short_frame_q  <= (state_q == StCapture) && (bit_cnt_q != '0);
        sync_err_q     <= 1'b0;
      end else begin
        if (mismatch) begin
          sync_err_q <= 1'b1;
        end
        case (state_q)
          StCapture: begin
            if (i_bit_valid) begin
              shift_q.valid      <= 1'b1;
              shift_q.decode_bit <= i_bit_value;
              bit_cnt_q          <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == LastBit) begin
                state_q <= StForward;
              end
            end
          end
          StForward: begin
            if (i_bit_valid && (fwd_cnt_q != '1)) begin
              fwd_cnt_q <= fwd_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_shift_reg   = shift_q;
  assign o_bit_count   = bit_cnt_q;
  assign o_fwd_count   = fwd_cnt_q;
  assign o_frame_done  = frame_done_q;
  assign o_short_frame = short_frame_q;
  assign o_sync_err    = sync_err_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Self-checking bench for ws2812_frame_sequencer: vector table plus directed frame sequences.

module tb_ws2812_frame_sequencer;

  logic       i_clk;
  logic       i_reset_n;
  logic       i_din;
  logic       i_bit_valid;
  logic       i_bit_value;
  logic       i_passthru_en;
  ws2812_frame_sequencer_pkg::shift_reg_input_t o_shift_reg;
  logic [4:0] o_bit_count;
  logic [3:0] o_fwd_count;
  logic       o_frame_done;
  logic       o_short_frame;
  logic       o_sync_err;

  int checks = 0;
  int errors = 0;

  ws2812_frame_sequencer #(
    .RESET_CYCLES (8),
    .FWD_CNT_W    (4)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_din         (i_din),
    .i_bit_valid   (i_bit_valid),
    .i_bit_value   (i_bit_value),
    .i_passthru_en (i_passthru_en),
    .o_shift_reg   (o_shift_reg),
    .o_bit_count   (o_bit_count),
    .o_fwd_count   (o_fwd_count),
    .o_frame_done  (o_frame_done),
    .o_short_frame (o_short_frame),
    .o_sync_err    (o_sync_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       din, bv, bval, pt;
    logic       ev, eb, et;
    logic [4:0] bc;
    logic [3:0] fc;
    logic       ed, es, ee;
  } vec_t;

  vec_t vq[$];

  // Packed view {valid, valid&bit, treset, bit_count, fwd_count, done, short, sync_err}
  function automatic logic [14:0] pk(input logic ev, input logic eb, input logic et,
                                     input logic [4:0] bc, input logic [3:0] fc,
                                     input logic ed, input logic es, input logic ee);
    return {ev, ev & eb, et, bc, fc, ed, es, ee};
  endfunction

  function automatic void add(input logic din, input logic bv, input logic bval,
                              input logic pt, input logic ev, input logic eb,
                              input logic et, input logic [4:0] bc, input logic [3:0] fc,
                              input logic ed, input logic es, input logic ee);
    vec_t v;
    v.din = din; v.bv = bv; v.bval = bval; v.pt = pt;
    v.ev = ev; v.eb = eb; v.et = et; v.bc = bc; v.fc = fc;
    v.ed = ed; v.es = es; v.ee = ee;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = pk(o_shift_reg.valid, o_shift_reg.decode_bit, o_shift_reg.treset, o_bit_count,
             o_fwd_count, o_frame_done, o_short_frame, o_sync_err);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b (v,bit,tr,bcnt,fcnt,done,short,err)",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic din, input logic bv, input logic bval, input logic pt);
    i_din         = din;
    i_bit_valid   = bv;
    i_bit_value   = bval;
    i_passthru_en = pt;
    @(posedge i_clk);
    #1;
  endtask

  // One high cycle, then 8 lows; counters hold until the 8th low produces treset.
  task automatic idle_to_treset(input logic pt, input logic [4:0] bc, input logic [3:0] fc,
                                input logic serr, input logic ed, input logic es,
                                input string nm);
    drive(1'b1, 1'b0, 1'b0, pt);
    chk({nm, "_hi"}, pk(1'b0, 1'b0, 1'b0, bc, fc, 1'b0, 1'b0, serr));
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b0, pt);
      chk($sformatf("%s_low%0d", nm, i), pk(1'b0, 1'b0, 1'b0, bc, fc, 1'b0, 1'b0, serr));
    end
    drive(1'b0, 1'b0, 1'b0, pt);
    chk({nm, "_treset"}, pk(1'b0, 1'b0, 1'b1, 5'd0, 4'd0, ed, es, 1'b0));
  endtask

  initial begin
    logic [9:0]  sbits;
    logic [23:0] pix;
    logic        b;
    logic [3:0]  fexp;

    i_reset_n     = 1'b0;
    i_din         = 1'b0;
    i_bit_valid   = 1'b0;
    i_bit_value   = 1'b0;
    i_passthru_en = 1'b0;
    #12;
    chk("reset_state", pk(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    #10;
    i_reset_n = 1'b1;

    // Strobes before any treset are dropped
    for (int i = 0; i < 5; i++) add(1, 1, i[0], 0, 0, 0, 0, 5'd0, 4'd0, 0, 0, 0);
    // First treset: one-cycle pulse after the 8th low, from WAIT_RESET so no pulses
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 5'd0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 0, 0, 0);
    // Short frame of 10 bits
    sbits = 10'b1011001110;
    for (int k = 0; k < 10; k++) begin
      b = sbits[9-k];
      add(1, 1, b, 0, 1, b, 0, 5'(k + 1), 4'd0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 5'(k + 1), 4'd0, 0, 0, 0);
    end
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 0, 5'd10, 4'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 5'd0, 4'd0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 0, 0, 0);
    // Collision of det_reset with a bit strobe, with zero bits captured
    add(1, 0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 5'd0, 4'd0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 1, 0, 5'd1, 4'd0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].din, vq[i].bv, vq[i].bval, vq[i].pt);
      chk($sformatf("vec%0d", i), pk(vq[i].ev, vq[i].eb, vq[i].et, vq[i].bc, vq[i].fc,
                                      vq[i].ed, vq[i].es, vq[i].ee));
    end

    // One bit captured so far: this treset ends a short frame
    idle_to_treset(1'b0, 5'd1, 4'd0, 1'b0, 1'b0, 1'b1, "pre_pixel");

    // Full pixel 0xA5C3F0, passthrough raised one cycle after the 24th strobe
    pix = 24'hA5C3F0;
    for (int k = 0; k < 24; k++) begin
      b = pix[23-k];
      drive(1'b1, 1'b1, b, 1'b0);
      chk($sformatf("pix_bit%0d", k), pk(1'b1, b, 1'b0, 5'(k + 1), 4'd0, 1'b0, 1'b0, 1'b0));
      drive(1'b1, 1'b0, 1'b0, (k == 23));
      chk($sformatf("pix_gap%0d", k), pk(1'b0, 1'b0, 1'b0, 5'(k + 1), 4'd0, 1'b0, 1'b0, 1'b0));
    end
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 1'b1, j[0], 1'b1);
      chk($sformatf("pix_fwd%0d", j), pk(1'b0, 1'b0, 1'b0, 5'd24, 4'(j + 1), 1'b0, 1'b0, 1'b0));
    end
    idle_to_treset(1'b1, 5'd24, 4'd8, 1'b0, 1'b1, 1'b0, "pixel");
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pixel_after", pk(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0));

    // Mismatch: passthrough never raised; also drives the forward counter into saturation
    for (int k = 0; k < 24; k++) begin
      drive(1'b1, 1'b1, k[0], 1'b0);
      chk($sformatf("mm_bit%0d", k), pk(1'b1, k[0], 1'b0, 5'(k + 1), 4'd0, 1'b0, 1'b0, 1'b0));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("mm_f1_exempt", pk(1'b0, 1'b0, 1'b0, 5'd24, 4'd0, 1'b0, 1'b0, 1'b0));
    for (int j = 0; j < 20; j++) begin
      fexp = (j >= 14) ? 4'd15 : 4'(j + 1);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("mm_fwd%0d", j), pk(1'b0, 1'b0, 1'b0, 5'd24, fexp, 1'b0, 1'b0, 1'b1));
    end
    idle_to_treset(1'b0, 5'd24, 4'd15, 1'b1, 1'b1, 1'b0, "mismatch");
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("mm_after", pk(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset mid-frame returns to WAIT_RESET
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      chk($sformatf("ar_bit%0d", k), pk(1'b1, 1'b1, 1'b0, 5'(k + 1), 4'd0, 1'b0, 1'b0, 1'b0));
    end
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("ar_immediate", pk(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    #2;
    i_reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      chk($sformatf("ar_drop%0d", k), pk(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    end
    idle_to_treset(1'b0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, "ar_treset");
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("ar_first_bit", pk(1'b1, 1'b1, 1'b0, 5'd1, 4'd0, 1'b0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
